// File: rtl/decode_issue_buffer_pkg.sv
// Shared types and MIPS opcode/funct constants for the decode issue buffer.
package decode_issue_buffer_pkg;

  typedef struct packed {
    logic       is_br;
    logic       is_hilo;
    logic       is_priv;
    logic [4:0] dst;
    logic       use_rs;
    logic       use_rt;
  } predecode_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;

  // Younger instruction reads a register the older one writes (r0 never counts).
  function automatic logic raw_hazard(predecode_t older, predecode_t younger,
                                      logic [4:0] rs, logic [4:0] rt);
    return (older.dst != 5'd0) &&
           ((younger.use_rs && (rs == older.dst)) ||
            (younger.use_rt && (rt == older.dst)));
  endfunction

endpackage

// File: rtl/decode_issue_buffer_predecode.sv
// Combinational pre-decode of one buffered instruction word into pairing attributes.
module issue_predecode
  import decode_issue_buffer_pkg::*;
(
  input  logic [31:0] i_instr,
  output predecode_t  o_pd
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_unused;

  assign w_op     = i_instr[31:26];
  assign w_fn     = i_instr[5:0];
  assign w_rt     = i_instr[20:16];
  assign w_rd     = i_instr[15:11];
  assign w_unused = ^{i_instr[25:21], i_instr[10:6]};

  // Anything not recognised is treated as privileged so it never pairs.
  always_comb begin
    o_pd = '0;
    case (w_op)
      OP_SPECIAL: begin
        case (w_fn)
          FN_SLL, FN_SRL, FN_SRA: begin
            o_pd.dst    = w_rd;
            o_pd.use_rt = 1'b1;
          end
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            o_pd.dst    = w_rd;
            o_pd.use_rs = 1'b1;
            o_pd.use_rt = 1'b1;
          end
          FN_JR: begin
            o_pd.is_br  = 1'b1;
            o_pd.use_rs = 1'b1;
          end
          FN_JALR: begin
            o_pd.is_br  = 1'b1;
            o_pd.dst    = w_rd;
            o_pd.use_rs = 1'b1;
          end
          FN_SYSCALL, FN_BREAK: o_pd.is_priv = 1'b1;
          FN_MFHI, FN_MFLO: begin
            o_pd.is_hilo = 1'b1;
            o_pd.dst     = w_rd;
          end
          FN_MTHI, FN_MTLO: begin
            o_pd.is_hilo = 1'b1;
            o_pd.use_rs  = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            o_pd.is_hilo = 1'b1;
            o_pd.use_rs  = 1'b1;
            o_pd.use_rt  = 1'b1;
          end
          default: o_pd.is_priv = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        o_pd.is_br  = 1'b1;
        o_pd.use_rs = 1'b1;
        o_pd.dst    = w_rt[4] ? 5'd31 : 5'd0;  // BLTZAL/BGEZAL link
      end
      OP_J:   o_pd.is_br = 1'b1;
      OP_JAL: begin
        o_pd.is_br = 1'b1;
        o_pd.dst   = 5'd31;
      end
      OP_BEQ, OP_BNE: begin
        o_pd.is_br  = 1'b1;
        o_pd.use_rs = 1'b1;
        o_pd.use_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        o_pd.is_br  = 1'b1;
        o_pd.use_rs = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        o_pd.dst    = w_rt;
        o_pd.use_rs = 1'b1;
      end
      OP_LUI: o_pd.dst = w_rt;
      OP_SB, OP_SH, OP_SW: begin
        o_pd.use_rs = 1'b1;
        o_pd.use_rt = 1'b1;
      end
      OP_COP0: o_pd.is_priv = 1'b1;
      default: o_pd.is_priv = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_buffer.sv
// Circular fetch-to-decode instruction queue with in-order dual-issue pairing at the head.
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [FETCH_W-1:0]       i_in_valid,
  input  logic [FETCH_W-1:0][31:0] i_in_pc,
  input  logic [FETCH_W-1:0][31:0] i_in_instr,
  output logic                     o_in_ready,
  output logic [ISSUE_W-1:0]       o_out_valid,
  output logic [ISSUE_W-1:0][31:0] o_out_pc,
  output logic [ISSUE_W-1:0][31:0] o_out_instr,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_lane_idx   [ISSUE_W];
  logic [31:0]      w_lane_instr [ISSUE_W];
  predecode_t       w_pd         [ISSUE_W];
  logic             w_lane0_ok;
  logic             w_push_en;
  logic [CNT_W-1:0] w_push_cnt;
  logic [CNT_W-1:0] w_pop_cnt;
  logic [CNT_W-1:0] w_push_amt;
  logic [CNT_W-1:0] w_pop_amt;

  assign o_count    = r_count;
  assign o_in_ready = (r_count <= CNT_W'(DEPTH - FETCH_W));
  assign w_push_en  = (|i_in_valid) && o_in_ready && !i_flush;

  for (genvar l = 0; l < ISSUE_W; l++) begin : g_lane
    assign w_lane_idx[l]   = r_head + PTR_W'(l);
    assign w_lane_instr[l] = r_instr[w_lane_idx[l]];
    assign o_out_pc[l]     = r_pc[w_lane_idx[l]];
    assign o_out_instr[l]  = w_lane_instr[l];
    issue_predecode u_predecode (.i_instr(w_lane_instr[l]), .o_pd(w_pd[l]));
  end

  // A lone branch waits for its delay slot when the slot could have paired with it.
  assign w_lane0_ok = !i_flush && (r_count != '0) &&
                      !((ISSUE_W == 2) && w_pd[0].is_br && (r_count < CNT_W'(2)));

  if (ISSUE_W == 2) begin : g_dual
    logic w_lane1_ok;
    logic w_unused_pd;
    assign w_unused_pd = ^{w_pd[0].use_rs, w_pd[0].use_rt, w_pd[1].dst};
    assign w_lane1_ok  = w_lane0_ok && (r_count >= CNT_W'(2)) &&
                         !w_pd[0].is_priv && !w_pd[1].is_priv && !w_pd[1].is_br &&
                         !(w_pd[0].is_hilo && w_pd[1].is_hilo) &&
                         !raw_hazard(w_pd[0], w_pd[1],
                                     w_lane_instr[1][25:21], w_lane_instr[1][20:16]);
    assign o_out_valid = {w_lane1_ok, w_lane0_ok};
  end else begin : g_single
    assign o_out_valid = w_lane0_ok;
  end

  // Push/pop amounts; out_valid is already zero during flush so pop needs no flush term.
  always_comb begin
    w_push_cnt = '0;
    w_pop_cnt  = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      w_push_cnt = w_push_cnt + CNT_W'(i_in_valid[k]);
    end
    for (int l = 0; l < ISSUE_W; l++) begin
      w_pop_cnt = w_pop_cnt + CNT_W'(o_out_valid[l]);
    end
    w_push_amt = w_push_en ? w_push_cnt : '0;
    w_pop_amt  = i_out_ready ? w_pop_cnt : '0;
  end

  // Queue pointers and occupancy; reset and flush override any push or pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_amt);
      r_tail  <= r_tail + PTR_W'(w_push_amt);
      r_count <= r_count + w_push_amt - w_pop_amt;
    end
  end

  // Entry storage is unreset; only slots covered by count are ever observed.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (w_push_en && i_in_valid[k]) begin
        r_pc[r_tail + PTR_W'(k)]    <= i_in_pc[k];
        r_instr[r_tail + PTR_W'(k)] <= i_in_instr[k];
      end
    end
  end

endmodule
